router_in_vc_port: RTL and testbench

- Parametrised router input port with two virtual channels (even/odd) for the cardinal ring NIC/CMP router.
- Accepts packets from an upstream link through a send/ready handshake and buffers each VC in its own FIFO.
- Raises a request toward the local PE output or the forward output according to the head packet's hop field, and pops that packet on grant.
- Only the VC whose parity matches the polarity signal may request in a given cycle.

---
 rtl/router_pkg.sv | 44 ++++
 rtl/router_vc_fifo.sv | 59 +++++
 rtl/router_in_vc_port.sv | 105 ++++++++++
 tb/tb_router_in_vc_port.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared constants, packet word type and hop-field helpers for
//                the cardinal ring router input port.
//  Revision    : 1.0  initial release
// ============================================================================
package router_pkg;

  // VC identifiers carried in the top bit of every packet
  localparam logic VC_EVEN = 1'b0;
  localparam logic VC_ODD  = 1'b1;

  // Widest packet the helpers can handle; narrower packets are zero-extended
  localparam int PKT_MAX_WIDTH = 256;

  typedef logic [PKT_MAX_WIDTH-1:0] pkt_word_t;

  // The VC bit is always the MSB of the packet
  function automatic int vc_bit_pos(input int data_width);
    return data_width - 1;
  endfunction

  // Mask covering the hop field in place
  function automatic pkt_word_t hop_mask(input int hop_lsb, input int hop_width);
    return ((pkt_word_t'(1) << hop_width) - pkt_word_t'(1)) << hop_lsb;
  endfunction

  // Hop field moved down to bit 0
  function automatic pkt_word_t hop_extract(input pkt_word_t word, input int hop_lsb,
                                            input int hop_width);
    return (word & hop_mask(hop_lsb, hop_width)) >> hop_lsb;
  endfunction

  // Word with its hop field logically shifted right by one, other bits intact
  function automatic pkt_word_t hop_shift(input pkt_word_t word, input int hop_lsb,
                                          input int hop_width);
    pkt_word_t m;
    m = hop_mask(hop_lsb, hop_width);
    return (word & ~m) | (((word & m) >> 1) & m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_vc_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : router_vc_fifo
//  Description : Single virtual-channel circular FIFO with show-ahead head.
//                All DEPTH entries are usable; occupancy tracked by a count.
//  Revision    : 1.0  initial release
// ============================================================================
module router_vc_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage array, no reset needed since empty state hides stale data
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/router_in_vc_port.sv
`default_nettype none
// ============================================================================
//  Module      : router_in_vc_port
//  Description : Router input port with even/odd virtual channels. Buffers
//                upstream packets per VC and requests the PE or forward
//                output for the head of the VC selected by polarity.
//                Optional macro ROUTER_IN_HOP_SHIFT_EN: dout_fwd carries the
//                head with its hop field shifted right by one.
//  Revision    : 1.0  initial release
// ============================================================================
module router_in_vc_port #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int HOP_LSB    = 48,
  parameter int HOP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  polarity,
  input  logic                  si,
  output logic                  ri,
  input  logic [DATA_WIDTH-1:0] di,
  output logic                  req_pe,
  output logic                  req_fwd,
  input  logic                  gnt_pe,
  input  logic                  gnt_fwd,
  output logic [DATA_WIDTH-1:0] dout_pe,
  output logic [DATA_WIDTH-1:0] dout_fwd,
  output logic [1:0]            full
);

  import router_pkg::*;

  localparam int VC_BIT = vc_bit_pos(DATA_WIDTH);

  logic [1:0]            push;
  logic [1:0]            pop;
  logic [1:0]            vc_full;
  logic [1:0]            vc_empty;
  logic [DATA_WIDTH-1:0] head [2];
  logic [DATA_WIDTH-1:0] head_av;
  logic                  nonempty_av;
  logic                  hop_zero;
  logic                  pop_av;
  pkt_word_t             head_wide;
  pkt_word_t             hop_wide;

  // Upstream is held off whenever either VC is full, independent of di
  assign ri   = ~vc_full[0] & ~vc_full[1];
  assign full = vc_full;

  generate
    for (genvar v = 0; v < 2; v++) begin : g_vc
      localparam logic VC_ID = (v == 1) ? VC_ODD : VC_EVEN;

      assign push[v] = si & ri & (di[VC_BIT] == VC_ID);
      assign pop[v]  = pop_av & (polarity == VC_ID);

      router_vc_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push[v]),
        .din   (di),
        .pop   (pop[v]),
        .head  (head[v]),
        .full  (vc_full[v]),
        .empty (vc_empty[v])
      );
    end
  endgenerate

  // Select the active VC head (zero when empty) and decode its hop field
  always_comb begin
    nonempty_av = ~vc_empty[polarity];
    head_av     = nonempty_av ? head[polarity] : '0;
    head_wide   = '0;
    head_wide[DATA_WIDTH-1:0] = head_av;
    hop_wide    = hop_extract(head_wide, HOP_LSB, HOP_WIDTH);
    hop_zero    = (hop_wide == '0);
  end

  assign req_pe  = nonempty_av & hop_zero;
  assign req_fwd = nonempty_av & ~hop_zero;

  // Requests are mutually exclusive, so simultaneous grants pop only once
  assign pop_av  = (gnt_pe & req_pe) | (gnt_fwd & req_fwd);

  assign dout_pe = head_av;

`ifdef ROUTER_IN_HOP_SHIFT_EN
  pkt_word_t shifted_wide;
  logic      unused_shift_hi;

  assign shifted_wide    = hop_shift(head_wide, HOP_LSB, HOP_WIDTH);
  assign dout_fwd        = shifted_wide[DATA_WIDTH-1:0];
  assign unused_shift_hi = ^shifted_wide[PKT_MAX_WIDTH-1:DATA_WIDTH];
`else
  assign dout_fwd = head_av;
`endif

endmodule
`default_nettype wire

// File: tb/tb_router_in_vc_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_router_in_vc_port
//  Description : Self-checking bench for router_in_vc_port against a
//                queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_router_in_vc_port;

  localparam int DW    = 64;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          polarity = 1'b0;
  logic          si = 1'b0;
  logic          ri;
  logic [DW-1:0] di = '0;
  logic          req_pe;
  logic          req_fwd;
  logic          gnt_pe = 1'b0;
  logic          gnt_fwd = 1'b0;
  logic [DW-1:0] dout_pe;
  logic [DW-1:0] dout_fwd;
  logic [1:0]    full;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];

  router_in_vc_port #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .HOP_LSB    (48),
    .HOP_WIDTH  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .polarity (polarity),
    .si       (si),
    .ri       (ri),
    .di       (di),
    .req_pe   (req_pe),
    .req_fwd  (req_fwd),
    .gnt_pe   (gnt_pe),
    .gnt_fwd  (gnt_fwd),
    .dout_pe  (dout_pe),
    .dout_fwd (dout_fwd),
    .full     (full)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model view of the active head for the current polarity
  function automatic logic [63:0] model_head(input logic p);
    if (p) return (q1.size() != 0) ? q1[0] : 64'h0;
    else   return (q0.size() != 0) ? q0[0] : 64'h0;
  endfunction

  function automatic logic model_nonempty(input logic p);
    return p ? (q1.size() != 0) : (q0.size() != 0);
  endfunction

  task automatic check_outputs();
    logic [63:0] h;
    logic [63:0] fwd;
    logic        ne;
    logic        exp_ri;
    h  = model_head(polarity);
    ne = model_nonempty(polarity);
    fwd = h;
`ifdef ROUTER_IN_HOP_SHIFT_EN
    fwd[55:48] = h[55:48] >> 1;
`endif
    exp_ri = (q0.size() < DEPTH) && (q1.size() < DEPTH);
    check_eq("ri", {63'h0, ri}, {63'h0, exp_ri});
    check_eq("full", {62'h0, full}, {62'h0, q1.size() == DEPTH, q0.size() == DEPTH});
    check_eq("req_pe", {63'h0, req_pe}, {63'h0, ne && (h[55:48] == 8'h0)});
    check_eq("req_fwd", {63'h0, req_fwd}, {63'h0, ne && (h[55:48] != 8'h0)});
    check_eq("dout_pe", dout_pe, h);
    check_eq("dout_fwd", dout_fwd, fwd);
  endtask

  // One cycle: drive inputs, check outputs, then advance the model at the edge
  task automatic step(input logic p, input logic s, input logic [63:0] d,
                      input logic gp, input logic gf);
    logic [63:0] h;
    logic        ne;
    logic        hz;
    logic        accept;
    logic        do_pop;
    @(negedge clk);
    polarity = p; si = s; di = d; gnt_pe = gp; gnt_fwd = gf;
    #1;
    check_outputs();
    @(posedge clk);
    ne     = model_nonempty(p);
    h      = model_head(p);
    hz     = (h[55:48] == 8'h0);
    accept = s && (q0.size() < DEPTH) && (q1.size() < DEPTH);
    do_pop = ne && ((gp && hz) || (gf && !hz));
    if (do_pop) begin
      if (p) void'(q1.pop_front());
      else   void'(q0.pop_front());
    end
    if (accept) begin
      if (d[63]) q1.push_back(d);
      else       q0.push_back(d);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; si = 1'b0; gnt_pe = 1'b0; gnt_fwd = 1'b0;
    @(posedge clk);
    q0.delete();
    q1.delete();
    @(negedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
  endtask

  function automatic logic [63:0] mk_pkt(input logic vc, input logic [7:0] hop,
                                         input logic [47:0] payload);
    return {vc, 7'h0, hop, payload};
  endfunction

  initial begin
    logic [63:0] d;
    logic        p;

    // Reset and idle
    apply_reset();
    step(0, 0, 64'h0, 0, 0);

    // Even packet, hop 0: PE request, then grant
    step(0, 1, 64'h0000_0000_0000_00AA, 0, 0);
    step(0, 0, 64'h0, 0, 0);
    step(0, 0, 64'h0, 1, 0);
    step(0, 0, 64'h0, 0, 0);

    // Odd packet with hop 4 under even polarity, then switch polarity
    step(0, 1, mk_pkt(1'b1, 8'h04, 48'h1234), 0, 0);
    step(0, 0, 64'h0, 0, 0);
    step(1, 0, 64'h0, 0, 0);
    @(negedge clk);
    #1;
`ifdef ROUTER_IN_HOP_SHIFT_EN
    check_eq("fwd_hop_shift", {56'h0, dout_fwd[55:48]}, 64'h02);
`else
    check_eq("fwd_hop_plain", {56'h0, dout_fwd[55:48]}, 64'h04);
`endif
    check_eq("pe_hop_plain", {56'h0, dout_pe[55:48]}, 64'h04);
    step(1, 0, 64'h0, 0, 1);

    // Fill even VC, fifth write dropped, one grant reopens, drain in order
    for (int i = 0; i < 5; i++) step(1, 1, mk_pkt(1'b0, 8'h00, 48'h100 + 48'(i)), 0, 0);
    step(0, 0, 64'h0, 1, 0);
    step(0, 1, mk_pkt(1'b0, 8'h00, 48'h1FF), 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 64'h0, 1, 0);
    step(0, 0, 64'h0, 0, 0);

    // Pointer wrap: concurrent writes and grants, both grants at once
    for (int i = 0; i < 10; i++)
      step(0, 1, mk_pkt(1'b0, (i % 2) ? 8'h03 : 8'h00, 48'h200 + 48'(i)), i > 0, i > 0);
    for (int i = 0; i < 4; i++) step(0, 0, 64'h0, 1, 1);
    step(0, 0, 64'h0, 0, 0);

    // Reset with two packets in each VC
    for (int i = 0; i < 4; i++) step(0, 1, mk_pkt(i[0], 8'(i), 48'h300 + 48'(i)), 0, 0);
    step(0, 0, 64'h0, 0, 0);
    apply_reset();
    step(1, 0, 64'h0, 0, 0);

    // Randomized traffic
    p = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) p = ~p;
      d = {$urandom, $urandom};
      if ($urandom_range(1) == 0) d[55:48] = 8'h00;
      step(p, $urandom_range(9) < 6, d, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
